// File: rtl/game_ctrl.sv
`default_nettype none
// ==========================================================================
// game_ctrl : snake game sequencer - move pacing, steering, food and score
// Revision  : 1.0  initial release
// ==========================================================================
module game_ctrl #(
  parameter int SPEED    = 8,
  parameter int SCAN_LEN = 220
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_frame,
  input  logic       i_start,
  input  logic [3:0] i_btn,
  input  logic [1:0] i_head_dir,
  input  logic [4:0] i_pos_x,
  input  logic [3:0] i_pos_y,
  input  logic       i_pos_first,
  input  logic       i_pos_valid,
  input  logic       i_failure,
  input  logic       i_success,
  output logic       o_snake_rst_n,
  output logic       o_tick,
  output logic [1:0] o_dir,
  output logic       o_eat,
  output logic [4:0] o_food_x,
  output logic [3:0] o_food_y,
  output logic       o_food_valid,
  output logic [1:0] o_state,
  output logic [7:0] o_score
);

  localparam int            CW         = $clog2(SCAN_LEN + 1);
  localparam logic [7:0]    SPEED_LAST = 8'(SPEED - 1);
  localparam logic [CW-1:0] WIN_LEN    = CW'(SCAN_LEN);
  localparam logic [CW-1:0] CHK_REST   = CW'(SCAN_LEN - 1);
  localparam logic [15:0]   LFSR_SEED  = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10,
    WIN  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    F_DRAW  = 2'b00,
    F_WAIT  = 2'b01,
    F_CHECK = 2'b10
  } food_t;

  state_t        state, state_nx;
  food_t         fphase;
  logic          snake_rst_n;
  logic [7:0]    frame_cnt;
  logic [CW-1:0] win_cnt;
  logic [CW-1:0] chk_cnt;
  logic [1:0]    dir;
  logic [15:0]   lfsr;
  logic [4:0]    cand_x, food_x;
  logic [3:0]    cand_y, food_y;
  logic          food_valid;
  logic [7:0]    score;

  logic          start_play;
  logic          win_active;
  logic          frame_hit;
  logic          win_open;
  logic [1:0]    rev_dir;
  logic          steer;
  logic [1:0]    steer_dir;
  logic          cand_ok;
  logic          cand_hit;
  logic          eat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      snake_rst_n <= 1'b0;
    end else begin
      state       <= state_nx;
      snake_rst_n <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx   = state;
    start_play = 1'b0;
    case (state)
      IDLE: if (i_start) begin
        state_nx   = PLAY;
        start_play = 1'b1;
      end
      PLAY: begin
        if (i_failure)      state_nx = OVER;
        else if (i_success) state_nx = WIN;
      end
      OVER, WIN: if (i_start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    win_active = (win_cnt != '0);
    frame_hit  = (frame_cnt == SPEED_LAST);
    win_open   = i_frame && frame_hit && !win_active;

    // A button asking for the exact opposite of the head is masked, so a
    // lower-priority button held alongside it still gets a chance.
    rev_dir   = i_head_dir ^ 2'b01;
    steer     = 1'b1;
    steer_dir = dir;
    if (i_btn[3] && rev_dir != 2'b01)      steer_dir = 2'b01;
    else if (i_btn[2] && rev_dir != 2'b00) steer_dir = 2'b00;
    else if (i_btn[1] && rev_dir != 2'b11) steer_dir = 2'b11;
    else if (i_btn[0] && rev_dir != 2'b10) steer_dir = 2'b10;
    else                                   steer     = 1'b0;

    cand_ok  = (lfsr[4:0] >= 5'd1) && (lfsr[4:0] <= 5'd20) &&
               (lfsr[8:5] >= 4'd1) && (lfsr[8:5] <= 4'd14);
    cand_hit = i_pos_valid && (i_pos_x == cand_x) && (i_pos_y == cand_y);
    eat      = (state == PLAY) && food_valid && i_pos_first && i_pos_valid &&
               (i_pos_x == food_x) && (i_pos_y == food_y);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt  <= '0;
      win_cnt    <= '0;
      chk_cnt    <= '0;
      dir        <= 2'b00;
      fphase     <= F_DRAW;
      cand_x     <= '0;
      cand_y     <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      score      <= '0;
    end else if (start_play) begin
      frame_cnt  <= '0;
      win_cnt    <= '0;
      chk_cnt    <= '0;
      dir        <= 2'b00;
      fphase     <= F_DRAW;
      food_valid <= 1'b0;
      score      <= '0;
    end else if (state == PLAY) begin
      if (win_open)        win_cnt <= WIN_LEN;
      else if (win_active) win_cnt <= win_cnt - 1'b1;

      if (i_frame) frame_cnt <= frame_hit ? 8'd0 : frame_cnt + 8'd1;

      // Steering is latched only between windows so a move never sees a change.
      if (!win_active && steer) dir <= steer_dir;

      if (food_valid) begin
        if (eat) begin
          food_valid <= 1'b0;
          fphase     <= F_DRAW;
          if (score != 8'hFF) score <= score + 8'd1;
        end
      end else begin
        case (fphase)
          F_DRAW: if (cand_ok) begin
            cand_x <= lfsr[4:0];
            cand_y <= lfsr[8:5];
            fphase <= F_WAIT;
          end
          F_WAIT: if (i_pos_first) begin
            if (cand_hit) begin
              fphase <= F_DRAW;
            end else if (CHK_REST == '0) begin
              food_x     <= cand_x;
              food_y     <= cand_y;
              food_valid <= 1'b1;
              fphase     <= F_DRAW;
            end else begin
              chk_cnt <= CHK_REST;
              fphase  <= F_CHECK;
            end
          end
          F_CHECK: begin
            if (cand_hit) begin
              fphase <= F_DRAW;
            end else if (chk_cnt == CW'(1)) begin
              food_x     <= cand_x;
              food_y     <= cand_y;
              food_valid <= 1'b1;
              fphase     <= F_DRAW;
            end else begin
              chk_cnt <= chk_cnt - 1'b1;
            end
          end
          default: fphase <= F_DRAW;
        endcase
      end
    end
  end

  assign o_snake_rst_n = snake_rst_n;
  assign o_tick        = (state == PLAY) && win_active;
  assign o_dir         = dir;
  assign o_eat         = eat;
  assign o_food_x      = food_x;
  assign o_food_y      = food_y;
  assign o_food_valid  = food_valid;
  assign o_state       = state;
  assign o_score       = score;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_game_ctrl : directed bench for game_ctrl
// Revision     : 1.0  initial release
// ==========================================================================
module tb_game_ctrl;

  localparam int SPEED    = 8;
  localparam int SCAN_LEN = 220;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_frame, i_start;
  logic [3:0] i_btn;
  logic [1:0] i_head_dir;
  logic [4:0] i_pos_x;
  logic [3:0] i_pos_y;
  logic       i_pos_first, i_pos_valid, i_failure, i_success;
  logic       o_snake_rst_n, o_tick, o_eat, o_food_valid;
  logic [1:0] o_dir, o_state;
  logic [4:0] o_food_x;
  logic [3:0] o_food_y;
  logic [7:0] o_score;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] m_lfsr;

  game_ctrl #(.SPEED(SPEED), .SCAN_LEN(SCAN_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .i_frame(i_frame), .i_start(i_start),
    .i_btn(i_btn), .i_head_dir(i_head_dir), .i_pos_x(i_pos_x), .i_pos_y(i_pos_y),
    .i_pos_first(i_pos_first), .i_pos_valid(i_pos_valid),
    .i_failure(i_failure), .i_success(i_success),
    .o_snake_rst_n(o_snake_rst_n), .o_tick(o_tick), .o_dir(o_dir), .o_eat(o_eat),
    .o_food_x(o_food_x), .o_food_y(o_food_y), .o_food_valid(o_food_valid),
    .o_state(o_state), .o_score(o_score)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference generator: seeded by reset, one step per clock.
  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  // Returns {y, x} of the first on-board candidate starting from l0.
  function automatic logic [8:0] first_legal(input logic [15:0] l0);
    logic [15:0] l;
    l = l0;
    for (int i = 0; i < 64; i++) begin
      if (l[4:0] >= 5'd1 && l[4:0] <= 5'd20 && l[8:5] >= 4'd1 && l[8:5] <= 4'd14)
        return l[8:0];
      l = lfsr_step(l);
    end
    return 9'h0;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      i_frame = 1'b1;
      @(negedge clk);
      i_frame = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  // One snake scan; body_idx < 0 means the scan carries no segments.
  task automatic scan(input int body_idx, input logic [4:0] bx, input logic [3:0] by,
                      output logic [15:0] snap);
    snap = 16'h0;
    for (int c = 0; c < SCAN_LEN; c++) begin
      i_pos_first = (c == 0);
      i_pos_valid = (c == body_idx);
      i_pos_x     = (c == body_idx) ? bx : 5'd0;
      i_pos_y     = (c == body_idx) ? by : 4'd0;
      @(negedge clk);
      if (c == body_idx) snap = m_lfsr;
    end
    i_pos_first = 1'b0;
    i_pos_valid = 1'b0;
    i_pos_x     = 5'd0;
    i_pos_y     = 4'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] snap1, snap2, snap3, dummy;
    logic [8:0]  c1, c2, c3;
    int          cnt;
    logic        dir_ok, bad;

    rst_n = 1'b0; i_frame = 1'b0; i_start = 1'b0; i_btn = 4'b0; i_head_dir = 2'b00;
    i_pos_x = 5'd0; i_pos_y = 4'd0; i_pos_first = 1'b0; i_pos_valid = 1'b0;
    i_failure = 1'b0; i_success = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_state",     16'(o_state),       16'd0);
    check("rst_snake_rst", 16'(o_snake_rst_n), 16'd0);
    check("rst_tick",      16'(o_tick),        16'd0);
    check("rst_eat",       16'(o_eat),         16'd0);
    check("rst_dir",       16'(o_dir),         16'd0);
    check("rst_food_v",    16'(o_food_valid),  16'd0);
    check("rst_food_x",    16'(o_food_x),      16'd0);
    check("rst_food_y",    16'(o_food_y),      16'd0);
    check("rst_score",     16'(o_score),       16'd0);

    rst_n = 1'b1;
    @(negedge clk);
    check("idle_hold", 16'(o_state), 16'd0);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    snap1 = m_lfsr;
    c1    = first_legal(snap1);
    check("start_snake_rst", 16'(o_snake_rst_n), 16'd1);
    check("start_state",     16'(o_state),       16'd1);

    // Steering
    i_btn = 4'b1000;
    repeat (2) @(negedge clk);
    check("dir_reverse_ignored", 16'(o_dir), 16'd0);
    i_btn = 4'b0001;
    @(negedge clk);
    check("dir_right", 16'(o_dir), 16'h2);
    i_head_dir = 2'b10; i_btn = 4'b1010;
    @(negedge clk);
    check("dir_up_over_left", 16'(o_dir), 16'h1);
    i_head_dir = 2'b01; i_btn = 4'b0110;
    @(negedge clk);
    check("dir_masked_down_left", 16'(o_dir), 16'h3);
    i_head_dir = 2'b00; i_btn = 4'b0001;
    @(negedge clk);
    check("dir_right_again", 16'(o_dir), 16'h2);
    i_btn = 4'b0000;

    // Tick window
    frames(SPEED - 1);
    check("tick_early", 16'(o_tick), 16'd0);
    i_frame = 1'b1;
    check("tick_pre", 16'(o_tick), 16'd0);
    @(negedge clk);
    i_frame = 1'b0;
    check("tick_rise", 16'(o_tick), 16'd1);
    cnt = 0; dir_ok = 1'b1;
    while (o_tick === 1'b1 && cnt < 400) begin
      cnt++;
      if (cnt == 50) i_btn = 4'b0010;
      if (o_dir !== 2'b10) dir_ok = 1'b0;
      @(negedge clk);
    end
    check("tick_len", 16'(cnt), 16'd220);
    check("dir_held_in_window", 16'(dir_ok), 16'd1);
    @(negedge clk);
    check("dir_after_window", 16'(o_dir), 16'h3);
    i_btn = 4'b0000;

    // Food placement: first candidate collides with a body segment
    scan(5, c1[4:0], c1[8:5], snap2);
    c2 = first_legal(snap2);
    @(negedge clk);
    check("food_rejected", 16'(o_food_valid), 16'd0);
    scan(-1, 5'd0, 4'd0, dummy);
    check("food_placed", 16'(o_food_valid), 16'd1);
    check("food_x", 16'(o_food_x), 16'(c2[4:0]));
    check("food_y", 16'(o_food_y), 16'(c2[8:5]));
    check("food_x_range", 16'(o_food_x >= 5'd1 && o_food_x <= 5'd20), 16'd1);
    check("food_y_range", 16'(o_food_y >= 4'd1 && o_food_y <= 4'd14), 16'd1);
    repeat (5) @(negedge clk);
    check("food_hold_x", 16'(o_food_x), 16'(c2[4:0]));

    // Eat
    i_pos_first = 1'b1; i_pos_valid = 1'b1; i_pos_x = c2[4:0]; i_pos_y = c2[8:5];
    #1;
    check("eat_pulse", 16'(o_eat), 16'd1);
    @(negedge clk);
    snap3 = m_lfsr;
    c3    = first_legal(snap3);
    #1;
    check("eat_single", 16'(o_eat), 16'd0);
    check("eat_food_drop", 16'(o_food_valid), 16'd0);
    check("eat_score", 16'(o_score), 16'd1);
    @(negedge clk);
    i_pos_first = 1'b0; i_pos_valid = 1'b0; i_pos_x = 5'd0; i_pos_y = 4'd0;
    repeat (70) @(negedge clk);
    scan(-1, 5'd0, 4'd0, dummy);
    check("refood_valid", 16'(o_food_valid), 16'd1);
    check("refood_x", 16'(o_food_x), 16'(c3[4:0]));
    check("refood_y", 16'(o_food_y), 16'(c3[8:5]));

    // Failure beats success; restart
    i_failure = 1'b1; i_success = 1'b1;
    @(negedge clk);
    i_failure = 1'b0; i_success = 1'b0;
    check("over_state", 16'(o_state), 16'h2);
    check("over_score_frozen", 16'(o_score), 16'd1);
    i_pos_first = 1'b1; i_pos_valid = 1'b1; i_pos_x = c3[4:0]; i_pos_y = c3[8:5];
    #1;
    check("over_no_eat", 16'(o_eat), 16'd0);
    check("over_no_tick", 16'(o_tick), 16'd0);
    @(negedge clk);
    i_pos_first = 1'b0; i_pos_valid = 1'b0;
    check("over_food_frozen", 16'(o_food_valid), 16'd1);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("over_to_idle", 16'(o_state), 16'd0);
    check("idle_snake_rst", 16'(o_snake_rst_n), 16'd0);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("replay_state", 16'(o_state), 16'd1);
    check("replay_score", 16'(o_score), 16'd0);
    check("replay_food_v", 16'(o_food_valid), 16'd0);
    check("replay_dir", 16'(o_dir), 16'd0);

    // Reset in the middle of a tick window
    frames(SPEED);
    repeat (97) @(negedge clk);
    check("tick_mid_window", 16'(o_tick), 16'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_tick", 16'(o_tick), 16'd0);
    check("midrst_state", 16'(o_state), 16'd0);
    check("midrst_snake_rst", 16'(o_snake_rst_n), 16'd0);
    bad = 1'b0;
    i_pos_first = 1'b1; i_pos_valid = 1'b1; i_pos_x = c3[4:0]; i_pos_y = c3[8:5];
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (o_tick !== 1'b0 || o_eat !== 1'b0) bad = 1'b1;
    end
    i_pos_first = 1'b0; i_pos_valid = 1'b0; i_pos_x = 5'd0; i_pos_y = 4'd0;
    check("midrst_no_residual", 16'(bad), 16'd0);
    check("midrst_food_v", 16'(o_food_valid), 16'd0);

    // Success path
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_success = 1'b1;
    @(negedge clk);
    i_success = 1'b0;
    check("win_state", 16'(o_state), 16'h3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter SPEED, default 8: number of i_frame pulses between game ticks (legal range 1..255).
REQ-002 Parameter SCAN_LEN, default 220: snake scan period in clocks; o_tick window length.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset: synchronous, active-low; clock: clk.
REQ-005 i_frame  in  1  one-clock pulse per video frame.
REQ-006 i_start  in  1  one-clock start/restart pulse.
REQ-007 i_btn  in  4  level buttons, already synchronized: [3]=up, [2]=down, [1]=left, [0]=right.
REQ-008 i_head_dir  in  2  current snake head direction.
REQ-009 i_pos_x  in  5 and i_pos_y  in  4  snake segment under scan.
REQ-010 i_pos_first, i_pos_valid, i_failure, i_success  in  1 each  snake scan status.
REQ-011 o_snake_rst_n  out  1  active-low reset to snake datapath.
REQ-012 o_tick  out  1  move request to snake.
REQ-013 o_dir  out  2  requested direction: 00=y+1, 01=y-1, 10=x+1, 11=x-1.
REQ-014 o_eat  out  1  one-clock grow pulse to snake.
REQ-015 o_food_x  out  5, o_food_y  out  4, o_food_valid  out  1  food cell.
REQ-016 o_state  out  2  00=IDLE, 01=PLAY, 10=OVER, 11=WIN.
REQ-017 o_score  out  8  food eaten this game.

Function
REQ-018 FSM: IDLE->PLAY on i_start; PLAY->OVER on i_failure; PLAY->WIN on i_success (failure wins if both in same cycle); OVER/WIN->IDLE on i_start; all other cases hold.
REQ-019 o_snake_rst_n is registered, 0 in IDLE and 1 in PLAY/OVER/WIN.
REQ-020 Entering PLAY clears o_score, frame counter, tick window and o_food_valid, and sets pending direction to 00.
REQ-021 In PLAY, the frame counter increments on i_frame; on the i_frame that makes the count equal SPEED, it clears and opens a tick window.
REQ-022 Tick window: o_tick=1 for exactly SCAN_LEN consecutive clocks from the cycle after the opening i_frame, then 0.
REQ-023 i_frame arriving while a window is open is still counted; a window never re-opens while one is active.
REQ-024 Pending direction is updated only in PLAY with the window closed; priority up(01) > down(00) > left(11) > right(10).
REQ-025 A button whose direction equals i_head_dir XOR 2'b01 (reversal) is ignored.
REQ-026 o_dir equals the pending direction and is constant for the whole tick window.
REQ-027 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, advances every clock, never all-zero.
REQ-028 Food placement when o_food_valid=0 in PLAY: candidate x=lfsr[4:0], y=lfsr[8:5].
REQ-029 A candidate is rejected and redrawn next clock unless 1<=x<=20 and 1<=y<=14.
REQ-030 An accepted candidate is checked over one full scan, starting at the next i_pos_first, through SCAN_LEN clocks.
REQ-031 Any cycle in that check with i_pos_valid=1 and i_pos_x/y equal to the candidate rejects it; a new draw follows.
REQ-032 A check that completes without a match sets o_food_x/y to the candidate and o_food_valid=1 on the following clock.
REQ-033 o_food_x/y hold their value while o_food_valid=1.
REQ-034 o_eat=1 for one clock when state=PLAY, o_food_valid=1, i_pos_first=1, i_pos_valid=1 and i_pos_x/y equal o_food_x/y.
REQ-035 In the cycle after o_eat, o_food_valid=0 and o_score increments, saturating at 255; at most one eat per food.
REQ-036 In OVER/WIN: o_tick=0, o_eat=0, and food, score and direction are frozen.
REQ-037 o_tick and o_eat are 0 in any cycle where state is not PLAY.

Reset
REQ-038 rst_n=0 at a clock edge forces state IDLE, o_snake_rst_n=0, o_tick=0, o_eat=0, o_dir=00, o_food_valid=0, o_food_x=0, o_food_y=0, o_score=0, counters=0 and LFSR=16'hACE1.
REQ-039 Reset mid-window or mid-check aborts that operation with no residual pulse after release.

Verification
REQ-040 Reset, i_start, SPEED=8 -> o_snake_rst_n=1 next clock; o_tick rises the clock after the 8th i_frame and stays high exactly 220 clocks.
REQ-041 Head dir 00, press up(01) -> ignored, o_dir stays 00; press right -> o_dir=10; press during window -> o_dir unchanged until window closes.
REQ-042 Scan model places a body segment at the first legal candidate -> that candidate is rejected; a free cell then yields o_food_valid=1 with x in 1..20, y in 1..14.
REQ-043 Head reaches food cell at i_pos_first -> single o_eat pulse, o_score 0->1, o_food_valid drops, then a new food is placed.
REQ-044 i_failure and i_success asserted in same cycle -> o_state=10; i_start -> IDLE; i_start again -> PLAY with o_score=0.
REQ-045 rst_n=0 for one clock 100 cycles into a tick window -> o_tick=0 and o_state=00 the next clock, with no o_eat pulse.
